// File: rtl/jtopl_bus_dec.sv
// CPU write decoder for the OPL register file: latches the register address,
// decodes data writes into register-file updates and holds them for a full slot sweep.
module jtopl_bus_dec #(
    parameter int HOLD     = 22,
    parameter int OPL_TYPE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [7:0] cpu_din,
    input  logic       cpu_addr,
    input  logic       cpu_cs_n,
    input  logic       cpu_wr_n,
    output logic       busy,
    output logic [7:0] din,
    output logic       write,
    output logic [3:0] sel_ch,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_wav,
    output logic       up_fnumlo,
    output logic       up_fnumhi,
    output logic       up_fbcon,
    output logic       rhy_en,
    output logic [4:0] rhy_kon,
    output logic       wave_mode,
    output logic [7:0] tim_a,
    output logic [7:0] tim_b,
    output logic [7:0] tim_ctl,
    output logic       up_timer
);

    localparam int CW = $clog2(HOLD + 1);

    typedef enum logic [2:0] {
        DEC_NONE,
        DEC_UPD,
        DEC_RHY,
        DEC_WAVE,
        DEC_TIMA,
        DEC_TIMB,
        DEC_TIMC
    } dec_e;

    logic          wr_req;
    logic          wr_req_l;
    logic          wr_evt;
    logic [7:0]    addr_q;
    logic [CW-1:0] hold_cnt;
    logic [7:0]    up_q;

    dec_e          dec_kind;
    logic [7:0]    dec_strobe;
    logic [3:0]    dec_ch;
    logic [1:0]    dec_group;
    logic [2:0]    dec_sub;
    logic [1:0]    op_group;
    logic [2:0]    op_sub;
    logic [2:0]    op_sub_m3;
    logic [3:0]    ch_idx;

    assign wr_req = !cpu_cs_n && !cpu_wr_n;
    assign wr_evt = wr_req && !wr_req_l;

    // Strobe vector order: mult, ksl_tl, ar_dr, sl_rr, wav, fnumlo, fnumhi, fbcon
    assign {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr,
            up_wav, up_fnumlo, up_fnumhi, up_fbcon} = up_q;

    assign op_group  = addr_q[4:3];
    assign op_sub    = addr_q[2:0];
    assign op_sub_m3 = (op_sub >= 3'd3) ? op_sub - 3'd3 : op_sub;
    assign ch_idx    = addr_q[3:0];

    always_comb begin
        dec_kind   = DEC_NONE;
        dec_strobe = '0;
        dec_ch     = '0;
        dec_group  = '0;
        dec_sub    = '0;
        if (addr_q == 8'hBD) begin
            dec_kind = DEC_RHY;
        end else if (addr_q == 8'h01) begin
            if (OPL_TYPE == 2) dec_kind = DEC_WAVE;
        end else if (addr_q == 8'h02) begin
            dec_kind = DEC_TIMA;
        end else if (addr_q == 8'h03) begin
            dec_kind = DEC_TIMB;
        end else if (addr_q == 8'h04) begin
            dec_kind = DEC_TIMC;
        end else if (addr_q[7:4] inside {4'hA, 4'hB, 4'hC}) begin
            if (ch_idx <= 4'd8) begin
                dec_kind  = DEC_UPD;
                dec_ch    = ch_idx;
                dec_group = (ch_idx >= 4'd6) ? 2'd2 : (ch_idx >= 4'd3) ? 2'd1 : 2'd0;
                dec_sub   = 3'(ch_idx - 4'(dec_group) * 4'd3);
                case (addr_q[7:4])
                    4'hA:    dec_strobe = 8'b0000_0100;
                    4'hB:    dec_strobe = 8'b0000_0010;
                    default: dec_strobe = 8'b0000_0001;
                endcase
            end
        end else if (op_sub <= 3'd5 && op_group <= 2'd2) begin
            // Operator slots: the channel repeats every three subslots within a group
            dec_group = op_group;
            dec_sub   = op_sub;
            dec_ch    = 4'(op_group) * 4'd3 + 4'(op_sub_m3);
            case (addr_q[7:5])
                3'd1: begin dec_kind = DEC_UPD; dec_strobe = 8'b1000_0000; end
                3'd2: begin dec_kind = DEC_UPD; dec_strobe = 8'b0100_0000; end
                3'd3: begin dec_kind = DEC_UPD; dec_strobe = 8'b0010_0000; end
                3'd4: begin dec_kind = DEC_UPD; dec_strobe = 8'b0001_0000; end
                3'd7: begin
                    if (OPL_TYPE == 2) begin
                        dec_kind   = DEC_UPD;
                        dec_strobe = 8'b0000_1000;
                    end
                end
                default: dec_kind = DEC_NONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        wr_req_l <= wr_req;
        if (rst) begin
            addr_q    <= '0;
            hold_cnt  <= '0;
            busy      <= 1'b0;
            write     <= 1'b0;
            din       <= '0;
            sel_ch    <= '0;
            sel_group <= '0;
            sel_sub   <= '0;
            up_q      <= '0;
            rhy_en    <= 1'b0;
            rhy_kon   <= '0;
            wave_mode <= 1'b0;
            tim_a     <= '0;
            tim_b     <= '0;
            tim_ctl   <= '0;
            up_timer  <= 1'b0;
        end else begin
            write    <= 1'b0;
            up_timer <= 1'b0;
            // The write cycle itself never counts, so the slot counter gets HOLD full ticks
            if (busy && cen && !write) begin
                hold_cnt <= hold_cnt - CW'(1);
                if (hold_cnt == CW'(1)) begin
                    busy <= 1'b0;
                    up_q <= '0;
                end
            end
            if (wr_evt) begin
                if (!cpu_addr) begin
                    addr_q <= cpu_din;
                end else if (!busy) begin
                    case (dec_kind)
                        DEC_UPD: begin
                            din       <= cpu_din;
                            write     <= 1'b1;
                            busy      <= 1'b1;
                            hold_cnt  <= CW'(HOLD);
                            up_q      <= dec_strobe;
                            sel_ch    <= dec_ch;
                            sel_group <= dec_group;
                            sel_sub   <= dec_sub;
                        end
                        DEC_RHY: begin
                            rhy_en  <= cpu_din[5];
                            rhy_kon <= cpu_din[4:0];
                        end
                        DEC_WAVE: wave_mode <= cpu_din[5];
                        DEC_TIMA: begin
                            tim_a    <= cpu_din;
                            up_timer <= 1'b1;
                        end
                        DEC_TIMB: begin
                            tim_b    <= cpu_din;
                            up_timer <= 1'b1;
                        end
                        DEC_TIMC: begin
                            tim_ctl  <= cpu_din;
                            up_timer <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/jtopl_bus_dec.md
Name: jtopl_bus_dec

Overview:
- CPU-side write decoder and update sequencer for the OPL register file.
- Accepts Yamaha-style two-step address/data bus writes and decodes the latched register address.
- Drives the register file's write interface: din, write, sel_ch/sel_group/sel_sub and one-hot up_* strobes.
- Holds each operator/channel update long enough for the slot counter to reach the target slot, and reports busy to the CPU; directly latches global registers (rhythm, wave mode, timers).

Parameters:
- HOLD, 22, cen ticks an operator/channel update stays selected: 18 slots plus pipeline depth to stage IV.
- OPL_TYPE, 1, 1 = OPL (0x01 bit5 and 0xE0 range ignored); 2 = OPL2 (wave select enabled).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cen  in  1  clock enable, the same enable that drives the slot counter
- cpu_din  in  8  CPU data bus
- cpu_addr  in  1  A0: 0 = address port, 1 = data port
- cpu_cs_n  in  1  chip select, active-low
- cpu_wr_n  in  1  write strobe, active-low
- busy  out  1  operator/channel update in progress
- din  out  8  data to register file
- write  out  1  one-clk pulse marking a new update
- sel_ch  out  4  channel 0-8
- sel_group  out  2  group 0-2
- sel_sub  out  3  subslot 0-5
- up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav  out  1 each  operator register strobes
- up_fnumlo, up_fnumhi, up_fbcon  out  1 each  channel register strobes
- rhy_en  out  1  register 0xBD bit5
- rhy_kon  out  5  register 0xBD bits4:0
- wave_mode  out  1  register 0x01 bit5 (forced 0 when OPL_TYPE=1)
- tim_a  out  8  register 0x02
- tim_b  out  8  register 0x03
- tim_ctl  out  8  register 0x04
- up_timer  out  1  one-clk pulse on any write to 0x02-0x04

Behaviour:
- Reset: every output is 0, the address latch is 0, and the hold counter is 0.
- Write event:
  - Detected on the clk where (!cpu_cs_n && !cpu_wr_n) first goes true (rising-edge detect of the qualifier).
  - Exactly one event per assertion, independent of cen.
- Address event (A0=0): addr_q <= cpu_din. Always accepted, even while busy.
- Data event (A0=1) while busy=1: ignored entirely; no output changes.
- Data event while busy=0: decode addr_q, as follows.
  - Operator ranges 0x20/0x40/0x60/0x80/0xE0 (+0x00..0x15):
    - Let o = addr[4:0]. Valid when o[2:0]<=5 and o[4:3]<=2; otherwise ignored.
    - sel_group = o[4:3], sel_sub = o[2:0], sel_ch = 3*sel_group + (sel_sub mod 3).
    - The matching up_* strobe goes high. The 0xE0 range is ignored when OPL_TYPE=1.
  - Channel ranges 0xA0/0xB0/0xC0 (+0..8):
    - Let c = addr[3:0]. Valid when c<=8; otherwise ignored.
    - sel_ch = c, sel_group = c/3, sel_sub = c mod 3.
    - Strobe up_fnumlo / up_fnumhi / up_fbcon respectively.
  - For a valid operator or channel write, on the next clk:
    - din <= data; write=1 for exactly one clk.
    - busy=1; hold counter loaded with HOLD.
  - 0xBD: rhy_en/rhy_kon updated next clk; no busy, no write.
  - 0x01: wave_mode <= data[5] (OPL_TYPE=2 only).
  - 0x02/0x03/0x04: the matching register is loaded and up_timer pulses for one clk.
  - All other addresses are ignored.
- Hold:
  - The counter decrements only on clk cycles with cen=1 and write=0.
  - When it reaches 0: all up_* strobes clear in the same clk and busy drops.
  - sel_*, din and up_* are stable throughout the hold.
  - If cen=0 the hold freezes indefinitely.
- Only one up_* strobe may be high at any time.
- Reset asserted mid-hold aborts the update: strobes, busy and counter clear on the next clk.

Test Plan:
- Reset with a write attempt in progress -> all outputs 0; busy 0 on the first post-reset clk.
- Addr 0x43, data 0x3F, cen every clk:
  - Next clk: write=1 for 1 clk, up_ksl_tl=1, din=0x3F, sel_group=0, sel_sub=3, sel_ch=0.
  - busy stays high exactly 22 cen ticks after write, then up_ksl_tl=0 and busy=0.
- Addr 0xA7, data 0x81 -> up_fnumlo=1, sel_ch=7, sel_group=2, sel_sub=1. Addr 0xA9 or 0x26 + any data -> no write, busy stays 0.
- During busy:
  - Addr 0xB0 then data 0x20 -> data dropped, strobes unchanged.
  - Address latch still updated: a data write after busy clears decodes 0xB0 -> up_fnumhi, sel_ch=0.
- Addr 0xBD, data 0x3F -> rhy_en=1, rhy_kon=5'h1F next clk, busy 0. Addr 0x03, data 0x55 -> tim_b=0x55 with a one-clk up_timer.
- OPL_TYPE=1: addr 0xE0 / 0x01 writes -> no up_wav, wave_mode stays 0. OPL_TYPE=2: addr 0x01, data 0x20 -> wave_mode=1.
